// File: rtl/serial_signed_addsub_pkg.sv
// Shared definitions for the serial signed adder/subtractor.
// Holds the FSM state encoding and the op-select encoding used by
// serial_signed_addsub.
package serial_signed_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_signed_addsub_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from Full_Adder cells.
// Ports:
//   a, b  : DIGIT-bit addends
//   cin   : carry-in
//   s     : DIGIT-bit sum
//   cout  : carry-out of the most significant bit
module Full_Adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);
    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        Full_Adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end

    assign cout = c[DIGIT];
endmodule

// File: rtl/serial_signed_addsub.sv
// Multi-cycle signed adder/subtractor. Processes DIGIT bits per clock,
// LSB digit first, and produces the exact (WIDTH+1)-bit signed result.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   in_valid   : operands A/B/cin/op valid
//   in_ready   : block is idle and can accept operands
//   A, B       : WIDTH-bit signed operands
//   cin        : carry-in (add) / borrow-in (sub)
//   op         : 0 -> A+B+cin, 1 -> A-B-cin
//   out_valid  : sum/ovf_w valid
//   out_ready  : consumer accepts the result
//   sum        : WIDTH+1-bit exact signed result
//   ovf_w      : result does not fit in WIDTH bits
module serial_signed_addsub
    import serial_signed_addsub_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf_w
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_signed_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t state, state_nx;

    logic [WIDTH-1:0]       a_reg, b_reg, res_reg;
    logic                   carry, sign_a, sign_b;
    logic [CW-1:0]          cnt;
    logic [WIDTH:0]         sum_reg;
    logic                   ovf_reg;

    logic [DIGIT-1:0]       d_sum;
    logic                   d_cout;
    logic                   accept, last;
    logic [WIDTH-1:0]       b_in;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_nx;
    logic [WIDTH:0]         sum_nx;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a   (a_reg[DIGIT-1:0]),
        .b   (b_reg[DIGIT-1:0]),
        .cin (carry),
        .s   (d_sum),
        .cout(d_cout)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_reg;
    assign ovf_w     = ovf_reg;

    assign accept = in_valid & in_ready;
    assign last   = (cnt == CW'(NDIG - 1));
    // Subtraction runs as A + ~B + ~cin; the inverted B also supplies sign_b.
    assign b_in   = (op == OP_SUB) ? ~B : B;

    // New digit enters from the top; concatenation keeps this valid when DIGIT == WIDTH.
    assign res_cat = {d_sum, res_reg};
    assign res_nx  = res_cat[WIDTH+DIGIT-1:DIGIT];
    // Sign-extended add of both operands: the extra top bit is sa ^ sb ^ carry-out.
    assign sum_nx  = {sign_a ^ sign_b ^ d_cout, res_nx};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept)    state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            carry   <= 1'b0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            cnt     <= '0;
            sum_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                a_reg   <= A;
                b_reg   <= b_in;
                carry   <= (op == OP_SUB) ? ~cin : cin;
                sign_a  <= A[WIDTH-1];
                sign_b  <= b_in[WIDTH-1];
                res_reg <= '0;
                cnt     <= '0;
            end
        end else if (state == RUN) begin
            a_reg   <= a_reg >> DIGIT;
            b_reg   <= b_reg >> DIGIT;
            carry   <= d_cout;
            res_reg <= res_nx;
            cnt     <= cnt + CW'(1);
            if (last) begin
                sum_reg <= sum_nx;
                ovf_reg <= sum_nx[WIDTH] ^ sum_nx[WIDTH-1];
            end
        end
    end

endmodule

// File: doc/serial_signed_addsub.md
Name: serial_signed_addsub

Overview:
- Parametrised, multi-cycle signed adder/subtractor. Computes an exact (WIDTH+1)-bit sign-extended result by processing DIGIT bits per clock through a carry register.
- Generalises the fixed 5-bit ripple adder in width and digit size, and adds subtract mode, an overflow flag and valid/ready handshakes.
- Sits between operand registers and the ALU result mux, where area matters more than latency.

Parameters:
- WIDTH, 5, operand width in bits (signed two's complement); must be >= 2.
- DIGIT, 1, bits processed per cycle; WIDTH % DIGIT must be 0 (elaboration error otherwise).
- NDIG, WIDTH/DIGIT (derived, localparam), cycles spent in RUN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- A  in  WIDTH  signed operand A.
- B  in  WIDTH  signed operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- op  in  1  0: A+B+cin; 1: A-B-cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH+1  signed exact result.
- ovf_w  out  1  result does not fit in WIDTH bits (sum[WIDTH] != sum[WIDTH-1]).

Behaviour:
- Reset (asynchronous, any state, including mid-RUN): state=IDLE, in_ready=1, out_valid=0, sum=0, ovf_w=0, digit counter=0, carry=0, operand registers=0. The operation in flight is discarded.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE:
  - On in_valid & in_ready, latch A into a_reg.
  - Latch b_reg = op ? ~B : B.
  - Latch carry = op ? ~cin : cin.
  - Latch sign_b = (op ? ~B : B)[WIDTH-1]; capture A[WIDTH-1] as sign_a.
  - Clear the result shift register and set counter=0. Go to RUN.
- RUN (one digit per cycle, LSB digit first):
  - Digit adder adds a_reg[DIGIT-1:0] + b_reg[DIGIT-1:0] + carry.
  - Its DIGIT sum bits shift into the result register from the top; a_reg and b_reg shift right by DIGIT; carry takes the digit carry-out.
  - counter increments. When counter==NDIG-1, go to DONE.
- DONE:
  - sum[WIDTH-1:0] = accumulated bits; sum[WIDTH] = sign_a ^ sign_b ^ final carry.
  - ovf_w is computed from the same result. sum and ovf_w are registered and stable for the whole of DONE.
  - Hold until out_ready=1, then return to IDLE on that edge. sum and ovf_w keep their values until the next DONE.
- Latency: out_valid rises exactly NDIG rising edges after the accepting edge. Minimum issue interval is NDIG+2 cycles (no accept in the DONE->IDLE handoff cycle).
- in_valid while not in IDLE is ignored; inputs must be held by the producer.
- Arithmetic: sum always equals the mathematically exact signed value:
  - range -2^WIDTH .. 2^WIDTH-1 for add;
  - -2^WIDTH .. 2^WIDTH-1 for sub.
  - Sub uses A + ~B + ~cin = A - B - cin.
- out_ready asserted in IDLE or RUN has no effect.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - op encoding (OP_ADD=0, OP_SUB=1).
- Sub-module digit_adder (param DIGIT): combinational DIGIT-bit ripple adder built from the existing Full_Adder cells; outputs DIGIT sum bits and carry-out.
- The FSM, shift registers and sign extension live in serial_signed_addsub.

Test Plan:
- WIDTH=5, DIGIT=1: A=7, B=9, op=0, cin=0 -> out_valid 5 edges after accept, sum=6'b010000 (16), ovf_w=1.
- WIDTH=5, DIGIT=1: A=-16, B=-16, op=0, cin=0 -> sum=6'b100000 (-32), ovf_w=1. Also A=-16, B=15, op=1, cin=1 -> sum=-32, ovf_w=1.
- WIDTH=8, DIGIT=4: A=100, B=-27, op=0, cin=1 -> sum=9'd74, ovf_w=0, out_valid 2 edges after accept. Hold out_ready=0 for 5 cycles -> sum stable, in_ready=0 throughout.
- Reset asserted asynchronously mid-RUN (WIDTH=8, DIGIT=1, counter=3) -> same cycle: in_ready=1, out_valid=0, sum=0. A new op issued after reset release returns its correct result.
- Back-to-back: keep in_valid=1 and out_ready=1, feed 4 random pairs -> 4 results in order, each matching the reference model, spaced NDIG+2 cycles apart.
- Random soak, WIDTH in {5,8,16} x DIGIT dividing WIDTH, random op/cin/backpressure, 10k ops -> sum == A±B±cin (exact) and ovf_w matches the fit check.
